// File: rtl/hazard_stall_controller.sv
// Hazard and stall sequencer for the 5-stage MIPS pipeline.
// Generates stall/flush controls for the fetch, decode and execute pipeline
// registers, the execute-operand forwarding selects, and schedules the
// multi-cycle HI/LO (mult/div) unit.
// Build option: define FORWARDING_EN to enable operand forwarding. When it is
// left undefined, forwards are tied to 00. Instead, decode stalls on any RAW
// hazard against the execute or memory stage. Writeback is covered by the
// write-first register file.
module hazard_stall_controller #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int COUNT_W     = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_decode,
    input  logic [4:0] rt_decode,
    input  logic [4:0] rs_execute,
    input  logic [4:0] rt_execute,
    input  logic [4:0] write_register_execute,
    input  logic       register_write_execute,
    input  logic       memory_to_register_execute,
    input  logic [4:0] write_register_memory,
    input  logic       register_write_memory,
    input  logic [4:0] write_register_writeback,
    input  logic       register_write_writeback,
    input  logic       hi_lo_start_execute,
    input  logic       hi_lo_divide_execute,
    input  logic       hi_lo_use_decode,
    input  logic       program_counter_multiplexer_jump_execute,
    output logic       stall_fetch,
    output logic       stall_decode,
    output logic       flush_decode,
    output logic       flush_execute,
    output logic [1:0] forward_a_execute,
    output logic [1:0] forward_b_execute,
    output logic       hi_lo_busy,
    output logic       hi_lo_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MULT = 2'b01,
        ST_DIV  = 2'b10
    } state_t;

    localparam logic [COUNT_W-1:0] MULT_LOAD = COUNT_W'(MULT_CYCLES - 1);
    localparam logic [COUNT_W-1:0] DIV_LOAD  = COUNT_W'(DIV_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CNT_ZERO  = {COUNT_W{1'b0}};
    localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1);

    state_t             state_q;
    logic [COUNT_W-1:0] count_q;
    logic               busy_q;

    logic load_use_s;
    logic hi_lo_stall_s;
    logic raw_stall_s;
    logic stall_any_s;

    // HI/LO scheduler: counts down the occupancy of the mult/div unit.
    // A start request while already busy is ignored; decode is held off anyway.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= CNT_ZERO;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hi_lo_start_execute) begin
                        busy_q <= 1'b1;
                        if (hi_lo_divide_execute) begin
                            state_q <= ST_DIV;
                            count_q <= DIV_LOAD;
                        end else begin
                            state_q <= ST_MULT;
                            count_q <= MULT_LOAD;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_MULT, ST_DIV: begin
                    if (count_q == CNT_ZERO) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        count_q <= count_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    count_q <= CNT_ZERO;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign hi_lo_busy = busy_q;
    assign hi_lo_done = busy_q && (count_q == CNT_ZERO);

    // A load in execute feeding either decode source needs one bubble; $0 never counts.
    assign load_use_s = memory_to_register_execute &&
                        (write_register_execute != 5'd0) &&
                        ((write_register_execute == rs_decode) ||
                         (write_register_execute == rt_decode));

    // HI/LO consumers wait until the unit is idle, including the start cycle itself.
    assign hi_lo_stall_s = hi_lo_use_decode && (busy_q || hi_lo_start_execute);

`ifdef FORWARDING_EN
    // Select the youngest in-flight producer of an execute operand; memory beats writeback.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] mem_dst,
                                           input logic       mem_wr,
                                           input logic [4:0] wb_dst,
                                           input logic       wb_wr);
        logic [1:0] sel;
        if (src == 5'd0) begin
            sel = 2'b00;
        end else if (mem_wr && (mem_dst == src)) begin
            sel = 2'b10;
        end else if (wb_wr && (wb_dst == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign forward_a_execute = fwd_sel(rs_execute, write_register_memory, register_write_memory,
                                       write_register_writeback, register_write_writeback);
    assign forward_b_execute = fwd_sel(rt_execute, write_register_memory, register_write_memory,
                                       write_register_writeback, register_write_writeback);
    assign raw_stall_s       = 1'b0;

    logic unused_fwd_s;
    assign unused_fwd_s = register_write_execute;
`else
    // Without forwarding, any decode source produced in execute or memory must wait.
    function automatic logic raw_hit(input logic [4:0] src,
                                     input logic [4:0] ex_dst,
                                     input logic       ex_wr,
                                     input logic [4:0] mem_dst,
                                     input logic       mem_wr);
        logic hit;
        if (src == 5'd0) begin
            hit = 1'b0;
        end else begin
            hit = (ex_wr && (ex_dst == src)) || (mem_wr && (mem_dst == src));
        end
        return hit;
    endfunction

    assign forward_a_execute = 2'b00;
    assign forward_b_execute = 2'b00;
    assign raw_stall_s = raw_hit(rs_decode, write_register_execute, register_write_execute,
                                 write_register_memory, register_write_memory) ||
                         raw_hit(rt_decode, write_register_execute, register_write_execute,
                                 write_register_memory, register_write_memory);

    logic unused_fwd_s;
    assign unused_fwd_s = ^{rs_execute, rt_execute, write_register_writeback,
                            register_write_writeback};
`endif

    assign stall_any_s = load_use_s || hi_lo_stall_s || raw_stall_s;

    // Combine hazards into pipeline controls; a taken branch/jump overrides any stall.
    always_comb begin
        stall_fetch   = 1'b0;
        stall_decode  = 1'b0;
        flush_decode  = 1'b0;
        flush_execute = 1'b0;
        if (program_counter_multiplexer_jump_execute) begin
            flush_decode  = 1'b1;
            flush_execute = 1'b1;
        end else if (stall_any_s) begin
            stall_fetch   = 1'b1;
            stall_decode  = 1'b1;
            flush_execute = 1'b1;
        end else begin
            stall_fetch   = 1'b0;
            stall_decode  = 1'b0;
        end
    end

endmodule
